// File: rtl/chesstypes_pkg.sv
// rtl/chesstypes_pkg.sv - shared chess move-generation types and handshake state encoding
package chesstypes;

  localparam int MAX_MOVES_DEFAULT = 8;

  typedef logic [5:0] square_t;

  // Shared between generators and collectors so both sides decode the handshake alike.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    RELEASE = 2'b10,
    READY   = 2'b11
  } collector_state_t;

endpackage

// File: rtl/king_move_collector_move_buffer.sv
// rtl/king_move_collector_move_buffer.sv - move register file, written at count, read at pointer
module move_buffer
  import chesstypes::*;
#(
  parameter int MAX_MOVES = MAX_MOVES_DEFAULT,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  square_t          wr_data,
  input  logic [CNT_W-1:0] rd_addr,
  output square_t          rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int IDX_W = $clog2(MAX_MOVES);

  square_t entries [MAX_MOVES];

  assign full    = (count == CNT_W'(MAX_MOVES));
  assign rd_data = entries[rd_addr[IDX_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (wr_en && !full) begin
      count <= count + CNT_W'(1);
    end
  end

  // Contents need no reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!clear && wr_en && !full) begin
      entries[count[IDX_W-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/king_move_collector.sv
// rtl/king_move_collector.sv - req/ack initiator that gathers generator moves and streams them out
module king_move_collector
  import chesstypes::*;
#(
  parameter int MAX_MOVES = MAX_MOVES_DEFAULT,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             req,
  input  logic             ack,
  input  logic             valid,
  input  square_t          position,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] move_count,
  output logic             overflow,
  input  logic             rd_en,
  output logic             rd_valid,
  output square_t          rd_data
);

  collector_state_t state, next_state;
  logic [CNT_W-1:0] rd_ptr;
  logic             clear;
  logic             wr_en;
  logic             pop;
  logic             full;

  move_buffer #(
    .MAX_MOVES (MAX_MOVES),
    .CNT_W     (CNT_W)
  ) u_move_buffer (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .wr_en   (wr_en),
    .wr_data (position),
    .rd_addr (rd_ptr),
    .rd_data (rd_data),
    .count   (move_count),
    .full    (full)
  );

  assign busy     = (state == REQ) || (state == RELEASE);
  assign done     = (state == READY);
  assign rd_valid = done && (rd_ptr < move_count);

  always_comb begin
    next_state = state;
    clear      = 1'b0;
    wr_en      = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = REQ;
          clear      = 1'b1;
        end
      end
      REQ: begin
        wr_en = valid;
        if (ack) next_state = RELEASE;
      end
      RELEASE: begin
        if (!ack) next_state = READY;
      end
      READY: begin
        // A restart takes priority over a pop in the same cycle.
        if (start) begin
          next_state = REQ;
          clear      = 1'b1;
        end else if (rd_en && rd_valid) begin
          pop = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req      <= 1'b0;
      overflow <= 1'b0;
      rd_ptr   <= '0;
    end else begin
      state <= next_state;
      req   <= (next_state == REQ);
      if (clear) begin
        overflow <= 1'b0;
        rd_ptr   <= '0;
      end else begin
        if (wr_en && full) overflow <= 1'b1;
        if (pop) rd_ptr <= rd_ptr + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/king_move_collector.md
Name: king_move_collector

Overview:
- Initiator side of the req/ack move-generator handshake. Raises req toward a piece move generator (e.g. the king generator), captures every valid/position beat into an 8-entry move buffer, and completes the four-phase handshake.
- Then presents the collected target squares to the search/evaluation logic as an in-order read stream.
- Sits between the move-search controller and one per-piece position generator.

Parameters:
- MAX_MOVES, 8, capacity of the move buffer (entries).
- CNT_W, 4, width of move_count; must satisfy 2**CNT_W > MAX_MOVES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request from the controller to begin a collection.
- req  out  1  handshake request to the generator; registered.
- ack  in  1  handshake acknowledge from the generator.
- valid  in  1  generator beat qualifier.
- position  in  6  generator target square, 0..63.
- busy  out  1  high in REQ and RELEASE.
- done  out  1  high while in READY.
- move_count  out  CNT_W  number of entries stored in the current collection.
- overflow  out  1  sticky for the current collection: a beat arrived with the buffer full.
- rd_en  in  1  consumer pop strobe.
- rd_valid  out  1  rd_data holds an unread entry.
- rd_data  out  6  buffer[rd_ptr], combinational from registers.

Behaviour:
- Reset (async, any state) clears all of the following immediately: state=IDLE; req=0; busy=0; done=0; move_count=0; overflow=0; rd_ptr=0; rd_valid=0. Buffer contents are don't-care.
- The FSM has four states, encoded in the shared package as IDLE=2'b00, REQ=2'b01, RELEASE=2'b10, READY=2'b11.
- IDLE:
  - req=0.
  - start=1 -> REQ on the next edge. On the same edge, clear move_count, overflow and rd_ptr; req becomes 1 one cycle after start.
- REQ:
  - req=1.
  - Each cycle with valid=1: if move_count<MAX_MOVES, write position to buffer[move_count] and increment move_count; else set overflow and drop the beat.
  - ack=1 sampled -> RELEASE. A valid beat in that same cycle is still captured.
  - Duplicate squares are stored as delivered, with no filtering.
- RELEASE:
  - req=0.
  - Stay while ack=1; ack=0 sampled -> READY. This tolerates a generator that holds ack any number of cycles after req falls.
  - valid is ignored.
- READY:
  - done=1.
  - rd_valid = (rd_ptr < move_count).
  - rd_en with rd_valid=1 advances rd_ptr on the next edge. rd_en with rd_valid=0 is ignored (no underflow, no error).
  - start=1 -> REQ: the same clear-and-request as from IDLE, discarding unread entries. start and rd_en in the same cycle: start wins and the pop is discarded.
- start is ignored in REQ and RELEASE.
- valid is ignored outside REQ.
- Zero-move collection: ack with no beats gives READY with move_count=0 and rd_valid=0.
- Latency:
  - start -> req high: 1 cycle.
  - ack sampled high -> req low: 1 cycle.
  - ack sampled low -> done: 1 cycle.
- Widths: move_count saturates at MAX_MOVES and never wraps. rd_ptr has CNT_W bits.

Decomposition:
- chesstypes package holds:
  - square_t (6-bit position type);
  - collector state enum/constants;
  - MAX_MOVES default;
  - the shared req/ack handshake state encoding, so generator and collector agree.
- Natural sub-module: move_buffer. It is a MAX_MOVES x 6 register file with write-at-count, read-at-pointer, a full flag and sync clear. The FSM stays in king_move_collector.

Test Plan:
- Basic collection:
  - Stimulus: start; generator returns valid beats 12, 13, 20 then ack, and holds ack 2 cycles after req falls.
  - Response: req high 1 cycle after start; move_count=3; done after ack low; reads give 12, 13, 20, then rd_valid=0.
- Overflow:
  - Stimulus: 10 beats 0..9 before ack.
  - Response: move_count=8; entries 0..7 stored; overflow=1.
- Empty collection:
  - Stimulus: ack with no beats.
  - Response: READY, move_count=0, rd_valid=0; rd_en ignored.
- Same-cycle capture:
  - Stimulus: beat 63 in the same cycle as the first ack=1.
  - Response: 63 stored as the last entry.
- Restart from READY:
  - Stimulus: start with unread entries, asserted together with rd_en.
  - Response: REQ entered; move_count and overflow cleared; rd_ptr=0.
- Reset mid-REQ:
  - Stimulus: rst asserted asynchronously mid-REQ.
  - Response: req=0 before the next clock edge; IDLE; all outputs zero; a new start works normally.
